// File: rtl/sram_bist_pkg.sv
`default_nettype none
// ============================================================================
// sram_bist_pkg: FSM states and March C- element encoding for sram_march_bist
// Rev 1.0
// ============================================================================
package sram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [2:0] c_elem_first = 3'd0;
   localparam logic [2:0] c_elem_last  = 3'd5;

   typedef struct packed {
      logic [2:0] idx;
      logic       down;    // walk addresses from depth_m1 down to 0
      logic       has_rd;
      logic       rd_val;  // expected data: 0 = bg, 1 = ~bg
      logic       has_wr;
      logic       wr_val;  // written data: 0 = bg, 1 = ~bg
   } march_elem_t;

   function automatic logic elem_is_down(input logic [2:0] idx);
      return (idx == 3'd3) || (idx == 3'd4);
   endfunction

   // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0)
   function automatic march_elem_t march_elem(input logic [2:0] idx);
      march_elem_t e;
      e      = '0;
      e.idx  = idx;
      e.down = elem_is_down(idx);
      case (idx)
         3'd0: begin
            e.has_wr = 1'b1;
            e.wr_val = 1'b0;
         end
         3'd1, 3'd3: begin
            e.has_rd = 1'b1;
            e.rd_val = 1'b0;
            e.has_wr = 1'b1;
            e.wr_val = 1'b1;
         end
         3'd2, 3'd4: begin
            e.has_rd = 1'b1;
            e.rd_val = 1'b1;
            e.has_wr = 1'b1;
            e.wr_val = 1'b0;
         end
         3'd5: begin
            e.has_rd = 1'b1;
            e.rd_val = 1'b0;
         end
         default: ;
      endcase
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bist_addr_gen.sv
`default_nettype none
// ============================================================================
// sram_bist_addr_gen: up/down march address counter with element-end flag
// Rev 1.0
// ============================================================================
module sram_bist_addr_gen #(
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              load_down_i,
   input  logic              step_i,
   input  logic              down_i,
   input  logic [ADDR_W-1:0] last_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              end_o
);

   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      addr_d = addr_q;
      if (load_i) begin
         addr_d = load_down_i ? last_i : '0;
      end else if (step_i) begin
         addr_d = down_i ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

   assign addr_o = addr_q;
   assign end_o  = down_i ? (addr_q == '0) : (addr_q == last_i);

endmodule
`default_nettype wire

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// sram_march_bist: March C- BIST controller for SRAM macros on a shared bus
// Rev 1.0
// ============================================================================
module sram_march_bist
   import sram_bist_pkg::*;
#(
   parameter int NUM_MACROS = 16,
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 32,
   parameter int WMASK_W    = 4,
   parameter int SEL_W      = $clog2(NUM_MACROS)
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic                         start,
   input  logic [SEL_W-1:0]             macro_sel,
   input  logic [ADDR_W-1:0]            depth_m1,
   input  logic [DATA_W-1:0]            bg,
   output logic [NUM_MACROS-1:0]        csb0,
   output logic                         web0,
   output logic [WMASK_W-1:0]           wmask0,
   output logic [ADDR_W-1:0]            addr0,
   output logic [DATA_W-1:0]            din0,
   input  logic [NUM_MACROS*DATA_W-1:0] dout0,
   output logic                         busy,
   output logic                         done,
   output logic                         pass,
   output logic [15:0]                  fail_count,
   output logic [ADDR_W-1:0]            first_fail_addr,
   output logic [DATA_W-1:0]            first_fail_data
);

   state_e              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   last_q, last_d;
   logic [DATA_W-1:0]   bg_q, bg_d;
   logic [2:0]          elem_q, elem_d;
   logic                phase_q, phase_d;
   logic                cmp_vld_q, cmp_vld_d;
   logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
   logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
   logic [15:0]         fail_cnt_q, fail_cnt_d;
   logic [ADDR_W-1:0]   ffa_q, ffa_d;
   logic [DATA_W-1:0]   ffd_q, ffd_d;

   march_elem_t         cur;
   logic                start_ok;
   logic                sel_oob;
   logic                is_rd;
   logic                addr_last_op;
   logic                run_done;
   logic                ag_load, ag_load_down, ag_step;
   logic [ADDR_W-1:0]   ag_addr;
   logic                ag_end;
   logic [DATA_W-1:0]   rd_data;

   assign cur      = march_elem(elem_q);
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign sel_oob  = 32'(macro_sel) >= NUM_MACROS;
   assign is_rd    = cur.has_rd && !phase_q;
   // Read-then-write elements spend two cycles per address; the rest spend one.
   assign addr_last_op = !(cur.has_rd && cur.has_wr) || phase_q;
   assign run_done     = addr_last_op && ag_end && (cur.idx == c_elem_last);

   sram_bist_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clk_i       (wb_clk_i),
      .rst_i       (wb_rst_i),
      .load_i      (ag_load),
      .load_down_i (ag_load_down),
      .step_i      (ag_step),
      .down_i      (cur.down),
      .last_i      (last_q),
      .addr_o      (ag_addr),
      .end_o       (ag_end)
   );

   always_comb begin
      rd_data = '0;
      for (int k = 0; k < NUM_MACROS; k++) begin
         if (sel_q == SEL_W'(k)) begin
            rd_data = dout0[k*DATA_W +: DATA_W];
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_ok) begin
               state_d = sel_oob ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (run_done) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      csb0   = '1;
      web0   = 1'b1;
      wmask0 = '0;
      addr0  = '0;
      din0   = '0;
      busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done   = (state_q == ST_DONE);
      pass   = (state_q == ST_DONE) && (fail_cnt_q == '0);
      if (state_q == ST_RUN) begin
         for (int k = 0; k < NUM_MACROS; k++) begin
            if (sel_q == SEL_W'(k)) begin
               csb0[k] = 1'b0;
            end
         end
         web0   = is_rd;
         wmask0 = '1;
         addr0  = ag_addr;
         din0   = is_rd ? '0 : (cur.wr_val ? ~bg_q : bg_q);
      end
   end

   // ----------------------------------------------------------- datapath
   always_comb begin
      sel_d        = sel_q;
      last_d       = last_q;
      bg_d         = bg_q;
      elem_d       = elem_q;
      phase_d      = phase_q;
      ag_load      = 1'b0;
      ag_load_down = 1'b0;
      ag_step      = 1'b0;
      cmp_vld_d    = 1'b0;
      cmp_exp_d    = cmp_exp_q;
      cmp_addr_d   = cmp_addr_q;
      fail_cnt_d   = fail_cnt_q;
      ffa_d        = ffa_q;
      ffd_d        = ffd_q;

      if (cmp_vld_q && (rd_data != cmp_exp_q)) begin
         if (fail_cnt_q != 16'hFFFF) begin
            fail_cnt_d = fail_cnt_q + 16'd1;
         end
         if (fail_cnt_q == '0) begin
            ffa_d = cmp_addr_q;
            ffd_d = rd_data;
         end
      end

      if (start_ok) begin
         sel_d      = macro_sel;
         last_d     = depth_m1;
         bg_d       = bg;
         elem_d     = c_elem_first;
         phase_d    = 1'b0;
         ag_load    = 1'b1;
         fail_cnt_d = sel_oob ? 16'hFFFF : 16'h0000;
         ffa_d      = '0;
         ffd_d      = '0;
      end else if (state_q == ST_RUN) begin
         if (is_rd) begin
            cmp_vld_d  = 1'b1;
            cmp_exp_d  = cur.rd_val ? ~bg_q : bg_q;
            cmp_addr_d = ag_addr;
         end
         if (!addr_last_op) begin
            phase_d = 1'b1;
         end else begin
            phase_d = 1'b0;
            if (!ag_end) begin
               ag_step = 1'b1;
            end else if (elem_q != c_elem_last) begin
               elem_d       = elem_q + 3'd1;
               ag_load      = 1'b1;
               ag_load_down = elem_is_down(elem_q + 3'd1);
            end
         end
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         sel_q      <= '0;
         last_q     <= '0;
         bg_q       <= '0;
         elem_q     <= c_elem_first;
         phase_q    <= 1'b0;
         cmp_vld_q  <= 1'b0;
         cmp_exp_q  <= '0;
         cmp_addr_q <= '0;
         fail_cnt_q <= '0;
         ffa_q      <= '0;
         ffd_q      <= '0;
      end else begin
         sel_q      <= sel_d;
         last_q     <= last_d;
         bg_q       <= bg_d;
         elem_q     <= elem_d;
         phase_q    <= phase_d;
         cmp_vld_q  <= cmp_vld_d;
         cmp_exp_q  <= cmp_exp_d;
         cmp_addr_q <= cmp_addr_d;
         fail_cnt_q <= fail_cnt_d;
         ffa_q      <= ffa_d;
         ffd_q      <= ffd_d;
      end
   end

   assign fail_count      = fail_cnt_q;
   assign first_fail_addr = ffa_q;
   assign first_fail_data = ffd_q;

endmodule
`default_nettype wire
